// File: rtl/md_unit.sv
// Multiply/divide unit for the MIPS EX stage: owns HI/LO, runs multi-cycle MULT/DIV/MADD
// with a fixed busy window and supports single-cycle MTHI/MTLO and in-flight cancel.
module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cancel,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MADD  = 3'd6,
      OP_RSVD  = 3'd7
   } op_t;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t            state_reg;
   op_t               op_reg;
   logic [CW-1:0]     cnt_reg;
   logic              busy_reg;
   logic [WIDTH-1:0]  a_reg, b_reg, hi_reg, lo_reg;

   logic [2*WIDTH-1:0] prod_s, prod_u, madd_sum;
   logic               div_signed, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

   assign busy = busy_reg;
   assign HI   = hi_reg;
   assign LO   = lo_reg;

   // Result is computed in one shot from the latched operands; HI/LO cannot change
   // while busy, so using the live HI/LO for MADD equals the value at acceptance.
   always_comb begin
      prod_s   = $signed({{WIDTH{a_reg[WIDTH-1]}}, a_reg}) *
                 $signed({{WIDTH{b_reg[WIDTH-1]}}, b_reg});
      prod_u   = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
      madd_sum = {hi_reg, lo_reg} + prod_s;

      div_signed = (op_reg == OP_DIV);
      a_neg      = div_signed & a_reg[WIDTH-1];
      b_neg      = div_signed & b_reg[WIDTH-1];
      a_mag      = a_neg ? (~a_reg + 1'b1) : a_reg;
      b_mag      = b_neg ? (~b_reg + 1'b1) : b_reg;
      b_safe     = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
      q_mag      = a_mag / b_safe;
      r_mag      = a_mag % b_safe;
      // Most-negative / -1 wraps naturally: magnitude 2^(W-1) negates to itself.
      quot       = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
      rem        = a_neg ? (~r_mag + 1'b1) : r_mag;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         op_reg    <= OP_MULT;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start && !cancel && op != OP_RSVD) begin
                  case (op_t'(op))
                     OP_MTHI: hi_reg <= A;
                     OP_MTLO: lo_reg <= A;
                     default: begin
                        op_reg    <= op_t'(op);
                        a_reg     <= A;
                        b_reg     <= B;
                        cnt_reg   <= (op == OP_DIV || op == OP_DIVU) ? CW'(DIV_CYCLES)
                                                                     : CW'(MULT_CYCLES);
                        busy_reg  <= 1'b1;
                        state_reg <= S_RUN;
                     end
                  endcase
               end
            end
            S_RUN: begin
               if (cancel) begin
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b0;
                  state_reg <= S_IDLE;
               end else if (cnt_reg == CW'(1)) begin
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b0;
                  state_reg <= S_IDLE;
                  case (op_reg)
                     OP_MULT:  {hi_reg, lo_reg} <= prod_s;
                     OP_MULTU: {hi_reg, lo_reg} <= prod_u;
                     OP_MADD:  {hi_reg, lo_reg} <= madd_sum;
                     OP_DIV, OP_DIVU: begin
                        if (b_reg != '0) begin
                           hi_reg <= rem;
                           lo_reg <= quot;
                        end
                     end
                     default: ;
                  endcase
               end else begin
                  cnt_reg <= cnt_reg - CW'(1);
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// Randomised and directed bench for md_unit, checked against a plain-arithmetic HI/LO model.
module tb_md_unit;
   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   logic          clk = 1'b0;
   logic          reset, start, cancel;
   logic [2:0]    op;
   logic [W-1:0]  A, B;
   logic          busy;
   logic [W-1:0]  HI, LO;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0;

   md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .cancel(cancel), .busy(busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int exp_cycles(input logic [2:0] o);
      if (o == 3'd0 || o == 3'd1 || o == 3'd6) return MC;
      if (o == 3'd2 || o == 3'd3) return DC;
      return 0;
   endfunction

   // Architectural effect of one accepted instruction on HI/LO.
   task automatic model_apply(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, p, q, r;
      logic [63:0] u;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         3'd0: begin p = sa * sb; {m_hi, m_lo} = p; end
         3'd1: begin u = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = u; end
         3'd2: if (b != 0) begin
                  q = sa / sb; r = sa % sb;
                  m_lo = q[31:0]; m_hi = r[31:0];
               end
         3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
         3'd4: m_hi = a;
         3'd5: m_lo = a;
         3'd6: begin p = longint'({m_hi, m_lo}) + sa * sb; {m_hi, m_lo} = p; end
         default: ;
      endcase
   endtask

   // Called at a negedge with busy low; returns at the first negedge with busy low again.
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int cycles;
      logic [W-1:0] old_hi, old_lo;
      old_hi = m_hi; old_lo = m_lo;
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; A = $urandom; B = $urandom;
      cycles = 0;
      while (busy && cycles < 100) begin
         if (cycles == 0) begin
            check("hold_hi", HI, old_hi);
            check("hold_lo", LO, old_lo);
         end
         cycles++;
         @(negedge clk);
      end
      check("busy_len", cycles, exp_cycles(o));
      model_apply(o, a, b);
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
      $display("op=%0d A=%h B=%h busy=%0d -> HI=%h LO=%h", o, a, b, cycles, HI, LO);
   endtask

   // Cancel a multi-cycle op while observing busy cycle 'at' (1-based).
   task automatic cancel_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int at);
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k < at; k++) @(negedge clk);
      check("cancel_busy_before", busy, 1'b1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("cancel_busy_after", busy, 1'b0);
      repeat (DC + 2) @(negedge clk);
      check("cancel_hi", HI, m_hi);
      check("cancel_lo", LO, m_lo);
      $display("cancel op=%0d at cycle %0d -> HI=%h LO=%h", o, at, HI, LO);
   endtask

   initial begin
      logic [2:0]   r_op;
      logic [W-1:0] r_a, r_b;
      reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; A = '0; B = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_hi", HI, 32'h0);
      check("rst_lo", LO, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of a MULT.
      run_op(3'd4, 32'h55, 32'h0);
      run_op(3'd5, 32'h66, 32'h0);
      start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd4;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("amid_busy", busy, 1'b0);
      check("amid_hi", HI, 32'h0);
      check("amid_lo", LO, 32'h0);
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      reset = 1'b0;
      repeat (MC + 3) @(negedge clk);
      check("amid_after_lo", LO, 32'h0);
      check("amid_after_busy", busy, 1'b0);
      $display("async reset mid MULT -> HI=%h LO=%h", HI, LO);

      run_op(3'd0, 32'hFFFFFFFE, 32'd5);
      check("mult_hi_lit", HI, 32'hFFFFFFFF);
      check("mult_lo_lit", LO, 32'hFFFFFFF6);
      run_op(3'd1, 32'hFFFFFFFE, 32'd5);
      check("multu_hi_lit", HI, 32'h00000004);
      run_op(3'd2, 32'hFFFFFFF9, 32'd2);
      check("div_lo_lit", LO, 32'hFFFFFFFD);
      check("div_hi_lit", HI, 32'hFFFFFFFF);
      run_op(3'd3, 32'd7, 32'd0);
      run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
      check("ovf_lo_lit", LO, 32'h80000000);
      check("ovf_hi_lit", HI, 32'h0);

      // MTLO while DIVU busy is dropped.
      start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
      @(posedge clk);
      @(negedge clk);
      op = 3'd5; A = 32'h1234;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 100 && busy; k++) @(negedge clk);
      check("divu_mtlo_busy", busy, 1'b0);
      check("divu_mtlo_lo", LO, 32'd14);
      check("divu_mtlo_hi", HI, 32'd2);
      m_lo = 32'd14; m_hi = 32'd2;
      $display("DIVU 100/7 with MTLO during busy -> HI=%h LO=%h", HI, LO);

      run_op(3'd4, 32'hABCD, 32'h0);
      run_op(3'd7, 32'hDEAD, 32'hBEEF);
      run_op(3'd4, 32'h0, 32'h0);
      run_op(3'd5, 32'hFFFFFFFF, 32'h0);
      run_op(3'd6, 32'd1, 32'd1);
      check("madd_hi_lit", HI, 32'd1);
      check("madd_lo_lit", LO, 32'd0);

      cancel_op(3'd0, 32'd6, 32'd7, 3);
      cancel_op(3'd0, 32'd6, 32'd7, MC);
      cancel_op(3'd2, 32'd99, 32'd4, 1);
      run_op(3'd0, 32'd6, 32'd7);
      check("mult42_lit", LO, 32'd42);

      // Cancel while idle blocks a same-edge MTHI.
      start = 1'b1; op = 3'd4; A = 32'h77; cancel = 1'b1;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      check("idle_cancel_hi", HI, m_hi);
      check("idle_cancel_busy", busy, 1'b0);
      $display("idle cancel with MTHI -> HI=%h", HI);

      for (int i = 0; i < 40; i++) begin
         r_op = 3'($urandom_range(0, 7));
         r_a  = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 7))
            0: r_b = 32'h0;
            1: r_b = 32'hFFFFFFFF;
            default: r_b = $urandom;
         endcase
         run_op(r_op, r_a, r_b);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS core. It sits in the EX stage beside the ALU and owns the HI/LO register pair.
- Executes MULT/MULTU/DIV/DIVU/MADD with configurable multi-cycle latency, plus single-cycle MTHI/MTLO.
- Exposes a busy flag so the stall logic can hold later HI/LO accesses.
- Supports cancel of an in-flight operation, used for exception flush.

Parameters:
WIDTH, 32, operand and HI/LO width (even, >=8)
MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request strobe for op, sampled on rising edge
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 reserved
A  input  WIDTH  operand rs (dividend / MTHI-MTLO source)
B  input  WIDTH  operand rt (divisor)
cancel  input  1  abort in-flight operation
busy  output  1  operation in progress
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
- Reset (async, any time including mid-operation):
  - HI=0, LO=0, busy=0.
  - Internal counter and latched operands cleared.
  - Pending result discarded.
- Accept rule: start sampled at an edge with busy=0 and cancel=0 and op!=7.
  - start while busy=1 is ignored; it is not queued.
  - op=7 is ignored.
- MTHI/MTLO:
  - At the accepting edge, HI<=A (or LO<=A).
  - busy stays 0, so the value is visible the next cycle.
- Multi-cycle ops:
  - At the accepting edge, A, B and op are latched and the counter is loaded with N.
  - N = MULT_CYCLES for MULT/MULTU/MADD; N = DIV_CYCLES for DIV/DIVU.
  - busy=1 for exactly N cycles after the accepting edge.
  - At the edge ending the Nth busy cycle, HI/LO update and busy falls together.
  - HI/LO keep their old values throughout busy.
  - Inputs A/B may change freely after acceptance.
- Arithmetic:
  - MULT: {HI,LO} = signed A × signed B, 2·WIDTH-bit product.
  - MULTU: {HI,LO} = unsigned A × unsigned B.
  - MADD: {HI,LO} = {HI,LO} + signed A × signed B, modulo 2^(2·WIDTH). The accumulate uses the HI/LO values present at the accepting edge.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = A / B, HI = A % B, unsigned.
  - Divide by zero (B=0): runs the full DIV_CYCLES, then HI/LO are left unchanged.
  - Signed overflow (most-negative ÷ −1): LO = most-negative, HI = 0.
- Cancel:
  - cancel=1 at an edge while busy: counter cleared, busy=0 next cycle, HI/LO unchanged, pending result dropped.
  - cancel on the final busy edge also drops the result.
  - cancel with busy=0 blocks a same-edge start (including MTHI/MTLO).
- Back-to-back: a new start is accepted on the edge at which busy is sampled 0. That edge can immediately follow the completion edge.
- Internal structure (one-shot or iterative) is free, but the outputs must match this timing exactly.

Test Plan:
- Reset mid-operation: MULT of 3×4 accepted, reset asserted asynchronously at busy cycle 2 → HI=0, LO=0, busy=0 immediately; no update afterward.
- Signed MULT: A=0xFFFFFFFE (−2), B=5 → busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF6. MULTU with the same operands → HI=0x00000004, LO=0xFFFFFFF6.
- DIV: A=−7 (0xFFFFFFF9), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 → busy 10 cycles, HI/LO unchanged.
- Busy handshake: MTLO of 0x1234 while a DIVU is busy → ignored, LO ends as the DIVU quotient. MTHI of 0xABCD on an idle cycle → HI=0xABCD next cycle, busy stays 0.
- MADD: HI=0, LO=0xFFFFFFFF, then MADD with A=1, B=1 → after 5 cycles HI=1, LO=0.
- Cancel: MULT of 6×7 accepted, cancel at busy cycle 3 → busy=0 the next cycle, HI/LO keep prior values. A subsequent MULT of 6×7 completes with LO=42.
